// File: rtl/neuron_ram_sweeper.sv
// rtl/neuron_ram_sweeper.sv - sweeps the neuron state RAM, hands valid words to the update unit, writes merged results back
module neuron_ram_sweeper #(
    parameter int INTEGER_WIDTH        = 16,
    parameter int DATA_WIDTH_FRAC      = 32,
    parameter int DATA_WIDTH           = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int TREF_WIDTH           = 5,
    parameter int NEURON_WIDTH_LOGICAL = 11,
    parameter int WORD_WIDTH           = 6 * DATA_WIDTH + TREF_WIDTH + 3 + NEURON_WIDTH_LOGICAL + 2,
    parameter int ADDR_WIDTH           = 9
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic [ADDR_WIDTH:0]         NumNeurons,
    output logic                        Busy,
    output logic                        Done,
    output logic                        RamChipEnable,
    output logic                        RamWriteEnable,
    output logic [ADDR_WIDTH-1:0]       RamAddress,
    output logic [WORD_WIDTH-1:0]       RamWriteData,
    input  logic [WORD_WIDTH-1:0]       RamReadData,
    output logic                        NeuronValid,
    input  logic                        NeuronReady,
    output logic [WORD_WIDTH-1:0]       NeuronWord,
    input  logic                        UpdateValid,
    input  logic [DATA_WIDTH-1:0]       UpdVmem,
    input  logic [DATA_WIDTH-1:0]       UpdGex,
    input  logic [DATA_WIDTH-1:0]       UpdGin,
    input  logic [TREF_WIDTH+2:0]       UpdRefVal
);

    localparam int DW        = DATA_WIDTH;
    localparam int RW        = TREF_WIDTH + 3;
    localparam int REF_LSB   = 3 * DW;
    localparam int GIN_LSB   = 3 * DW + RW;
    localparam int GEX_LSB   = 4 * DW + RW;
    localparam int VMEM_LSB  = 5 * DW + RW;
    localparam int VALID_BIT = 6 * DW + RW + 1;

    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_PRESENT,
        S_WAIT_UPD,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH:0]   num_neurons;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] neuron_word;
    logic [WORD_WIDTH-1:0] write_data;
    logic [WORD_WIDTH-1:0] merged_word;
    logic                  last_addr;
    logic                  read_valid;

    // The count is one bit wider than the address so a full 2**AW sweep terminates without wrapping.
    assign last_addr  = ({1'b0, addr} == (num_neurons - COUNT_ONE));
    assign read_valid = RamReadData[VALID_BIT];

    always_comb begin
        merged_word = neuron_word;
        merged_word[VMEM_LSB +: DW] = UpdVmem;
        merged_word[GEX_LSB  +: DW] = UpdGex;
        merged_word[GIN_LSB  +: DW] = UpdGin;
        merged_word[REF_LSB  +: RW] = UpdRefVal;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:     if (Start) next_state = (NumNeurons == '0) ? S_FINISH : S_READ;
            S_READ:     next_state = S_LATCH;
            S_LATCH: begin
                if (read_valid)     next_state = S_PRESENT;
                else if (last_addr) next_state = S_FINISH;
                else                next_state = S_READ;
            end
            S_PRESENT:  if (NeuronReady) next_state = S_WAIT_UPD;
            S_WAIT_UPD: if (UpdateValid) next_state = S_WRITE;
            S_WRITE:    next_state = last_addr ? S_FINISH : S_READ;
            S_FINISH:   next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            num_neurons <= '0;
            addr        <= '0;
            neuron_word <= '0;
            write_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        num_neurons <= NumNeurons;
                        addr        <= '0;
                    end
                end
                S_LATCH: begin
                    neuron_word <= RamReadData;
                    if (!read_valid && !last_addr) addr <= addr + ADDR_ONE;
                end
                S_WAIT_UPD: begin
                    if (UpdateValid) write_data <= merged_word;
                end
                S_WRITE: begin
                    if (!last_addr) addr <= addr + ADDR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // RAM strobes are masked by Reset so a write-back cut short by reset never reaches the array.
    always_comb begin
        Busy           = (state != S_IDLE);
        Done           = (state == S_FINISH);
        NeuronValid    = (state == S_PRESENT);
        RamChipEnable  = !Reset && ((state == S_READ) || (state == S_WRITE));
        RamWriteEnable = !Reset && (state == S_WRITE);
    end

    assign RamAddress   = addr;
    assign NeuronWord   = neuron_word;
    assign RamWriteData = write_data;

endmodule

// File: tb/tb_neuron_ram_sweeper.sv
// tb/tb_neuron_ram_sweeper.sv - scoreboard bench for neuron_ram_sweeper with a behavioural single-port RAM
module tb_neuron_ram_sweeper;

    localparam int WW = 309;
    localparam int AW = 9;

    logic          Clock = 0;
    logic          Reset = 1;
    logic          Start = 0;
    logic [AW:0]   NumNeurons = '0;
    logic          Busy, Done, RamChipEnable, RamWriteEnable, NeuronValid;
    logic [AW-1:0] RamAddress;
    logic [WW-1:0] RamWriteData, NeuronWord;
    logic [WW-1:0] RamReadData = '0;
    logic          NeuronReady = 0;
    logic          UpdateValid = 0;
    logic [47:0]   UpdVmem, UpdGex, UpdGin;
    logic [7:0]    UpdRefVal;

    neuron_ram_sweeper dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .NumNeurons(NumNeurons),
        .Busy(Busy), .Done(Done), .RamChipEnable(RamChipEnable), .RamWriteEnable(RamWriteEnable),
        .RamAddress(RamAddress), .RamWriteData(RamWriteData), .RamReadData(RamReadData),
        .NeuronValid(NeuronValid), .NeuronReady(NeuronReady), .NeuronWord(NeuronWord),
        .UpdateValid(UpdateValid), .UpdVmem(UpdVmem), .UpdGex(UpdGex), .UpdGin(UpdGin),
        .UpdRefVal(UpdRefVal)
    );

    always #5 Clock = ~Clock;

    function automatic logic [47:0] f_vmem(input logic [10:0] nid);
        return {5'h15, nid, 32'hC0DE_0001};
    endfunction
    function automatic logic [47:0] f_gex(input logic [10:0] nid);
        return {nid, 37'h1_2345_6789};
    endfunction
    function automatic logic [47:0] f_gin(input logic [10:0] nid);
        return {32'h600D_F00D, 5'h0, nid};
    endfunction
    function automatic logic [7:0] f_ref(input logic [10:0] nid);
        return nid[7:0] ^ 8'h5A;
    endfunction

    // The stand-in update unit derives new state from the neuron ID of the presented word.
    logic [10:0] cur_nid;
    assign cur_nid   = NeuronWord[308:298];
    assign UpdVmem   = f_vmem(cur_nid);
    assign UpdGex    = f_gex(cur_nid);
    assign UpdGin    = f_gin(cur_nid);
    assign UpdRefVal = f_ref(cur_nid);

    logic [WW-1:0] mem      [0:511];
    logic [WW-1:0] init_mem [0:511];
    logic          load_req = 0;

    always @(posedge Clock) begin
        if (load_req) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_mem[i];
        end else if (RamChipEnable) begin
            if (RamWriteEnable) mem[RamAddress] <= RamWriteData;
            else                RamReadData     <= mem[RamAddress];
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_ce = 0;
    int n_writes = 0;
    int n_present = 0;
    int last_ce_addr = -1;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (RamChipEnable) begin
            n_ce++;
            last_ce_addr = int'(RamAddress);
        end
        if (NeuronValid && NeuronReady) n_present++;
        if (RamChipEnable && RamWriteEnable) begin
            wr_t w;
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {1'b0, RamAddress}, 320'h200);
            end else begin
                w = exp_q.pop_front();
                check("write_addr", RamAddress, w.a);
                check("write_data", RamWriteData, w.d);
            end
        end
    end

    function automatic logic [WW-1:0] make_word(input bit valid);
        logic [63:0] r;
        logic [47:0] f [0:5];
        logic [7:0]  rv;
        logic [10:0] nid;
        for (int i = 0; i < 6; i++) begin
            r = {$urandom(), $urandom()};
            f[i] = r[47:0];
        end
        rv  = 8'($urandom());
        nid = 11'($urandom_range(0, 2047));
        return {nid, valid, 1'($urandom()), f[5], f[4], f[3], rv, f[2], f[1], f[0]};
    endfunction

    task automatic push_expected(input int a);
        wr_t w;
        logic [WW-1:0] o;
        o = init_mem[a];
        w.a = AW'(a);
        w.d = {o[308:298], o[297], o[296], f_vmem(o[308:298]), f_gex(o[308:298]),
               f_gin(o[308:298]), f_ref(o[308:298]), o[143:96], o[95:48], o[47:0]};
        exp_q.push_back(w);
    endtask

    task automatic load_mem();
        @(posedge Clock); #1 load_req = 1;
        @(posedge Clock); #1 load_req = 0;
        n_ce = 0; n_writes = 0; n_present = 0; last_ce_addr = -1;
    endtask

    task automatic pulse_start(input int n);
        @(posedge Clock); #1;
        NumNeurons = (AW+1)'(n);
        Start = 1;
        @(posedge Clock); #1;
        Start = 0;
        NumNeurons = '0;
    endtask

    task automatic wait_done(input string tag, input bit mid_start, output int lat);
        bit seen;
        seen = 0;
        lat = 1;
        for (int k = 0; k < 6000; k++) begin
            if (Done) begin
                seen = 1;
                break;
            end
            if (mid_start && k == 7) begin
                Start = 1;
                NumNeurons = 10'd5;
            end else begin
                Start = 0;
                NumNeurons = '0;
            end
            @(posedge Clock); #1;
            lat++;
        end
        Start = 0;
        if (!seen) begin
            check({tag, "_timeout"}, Done, 1);
            lat = -1;
        end
    endtask

    task automatic run_sweep(input int n, input int exp_lat, input bit mid_start, input string tag);
        int lat;
        pulse_start(n);
        wait_done(tag, mid_start, lat);
        check({tag, "_latency"}, lat, exp_lat);
        @(posedge Clock); #1;
        check({tag, "_idle_after"}, {Busy, Done}, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int lat_exp;
        int lat;
        bit seen;

        for (int i = 0; i < 512; i++) init_mem[i] = make_word(0);
        repeat (3) @(posedge Clock);
        #1 Reset = 0;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_ce", RamChipEnable, 0);
        check("rst_we", RamWriteEnable, 0);
        check("rst_nvalid", NeuronValid, 0);
        check("rst_addr", RamAddress, 0);
        check("rst_nword", NeuronWord, 0);
        check("rst_wdata", RamWriteData, 0);

        // Three valid neurons, handshakes always ready
        NeuronReady = 1;
        UpdateValid = 1;
        for (int i = 0; i < 3; i++) init_mem[i] = make_word(1);
        load_mem();
        for (int i = 0; i < 3; i++) push_expected(i);
        run_sweep(3, 16, 0, "sweep3");
        check("sweep3_writes", n_writes, 3);

        // Invalid words at 0 and 2 are skipped
        init_mem[0] = make_word(0);
        init_mem[1] = make_word(1);
        init_mem[2] = make_word(0);
        load_mem();
        push_expected(1);
        run_sweep(3, 10, 0, "skip");
        check("skip_presented", n_present, 1);
        check("skip_writes", n_writes, 1);

        // Update unit holds off NeuronReady for 4 cycles
        init_mem[0] = make_word(1);
        load_mem();
        push_expected(0);
        NeuronReady = 0;
        pulse_start(1);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (NeuronValid) begin
                seen = 1;
                break;
            end
            @(posedge Clock); #1;
        end
        check("stall_presented", seen, 1);
        check("stall_word", NeuronWord, init_mem[0]);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock); #1;
            check("stall_nvalid_held", NeuronValid, 1);
            check("stall_word_held", NeuronWord, init_mem[0]);
            check("stall_busy", Busy, 1);
        end
        check("stall_ram_idle", n_ce, 1);
        NeuronReady = 1;
        wait_done("stall", 0, lat);
        check("stall_writes", n_writes, 1);
        check("stall_queue_empty", exp_q.size(), 0);

        // Empty sweep
        load_mem();
        run_sweep(0, 1, 0, "empty");
        check("empty_no_ce", n_ce, 0);

        // Reset while waiting for the update, then a fresh sweep
        init_mem[0] = make_word(1);
        init_mem[1] = make_word(1);
        load_mem();
        UpdateValid = 0;
        pulse_start(2);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (NeuronValid) begin
                seen = 1;
                break;
            end
            @(posedge Clock); #1;
        end
        check("rstmid_presented", seen, 1);
        repeat (3) @(posedge Clock);
        #1 Reset = 1;
        @(posedge Clock); #1 Reset = 0;
        check("rstmid_busy", Busy, 0);
        check("rstmid_ce", RamChipEnable, 0);
        check("rstmid_we", RamWriteEnable, 0);
        check("rstmid_nvalid", NeuronValid, 0);
        check("rstmid_nword", NeuronWord, 0);
        check("rstmid_no_write", n_writes, 0);
        UpdateValid = 1;
        push_expected(0);
        push_expected(1);
        run_sweep(2, 11, 0, "rstmid_fresh");

        // Full-size sweep with a stray Start mid-run
        lat_exp = 1;
        for (int i = 0; i < 512; i++) begin
            init_mem[i] = make_word(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            lat_exp += init_mem[i][297] ? 5 : 2;
        end
        load_mem();
        for (int i = 0; i < 512; i++) if (init_mem[i][297]) push_expected(i);
        run_sweep(512, lat_exp, 1, "full");
        check("full_last_addr", last_ce_addr, 511);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
